// File: rtl/spi_byte_sender_if.sv
// Byte-sender bus: load strobes from the core, SCLK/CS from the host side,
// serial data and pacing status back out.
interface spi_byte_sender_if #(
   parameter int NBYTES = 4
);
   logic                  send;
   logic [8*NBYTES-1:0]   send_data;
   logic [NBYTES-1:0]     send_en;
   logic                  writeMeta;
   logic [7:0]            meta_data;
   logic                  cs_n;
   logic                  sclk_rise;
   logic                  sclk_fall;
   logic                  miso;
   logic                  dataReady;
   logic                  xmit_idle;
   logic                  overrun;

   modport master (
      output send, send_data, send_en, writeMeta, meta_data,
      output cs_n, sclk_rise, sclk_fall,
      input  miso, dataReady, xmit_idle, overrun
   );

   modport slave (
      input  send, send_data, send_en, writeMeta, meta_data,
      input  cs_n, sclk_rise, sclk_fall,
      output miso, dataReady, xmit_idle, overrun
   );
endinterface

// File: rtl/spi_byte_sender.sv
// Queues a metadata byte or up to NBYTES enabled sample bytes and shifts
// them MSB-first to the SPI host, resending a byte if CS drops mid-byte.
module spi_byte_sender #(
   parameter int NBYTES = 4
) (
   input logic              clock,
   input logic              extReset,
   spi_byte_sender_if.slave bus
);
   localparam int CW = $clog2(NBYTES + 1);
   localparam int PW = $clog2(NBYTES);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, NEXT} state_t;

   state_t        state;
   logic [7:0]    q [NBYTES];
   logic [CW-1:0] count;
   logic [PW-1:0] rdptr;
   logic [2:0]    bitcnt;
   logic [7:0]    shreg;
   logic [7:0]    hold;
   logic          cs_q;
   logic          miso;
   logic          overrun;
   logic          idle;
   logic          strobe;
   logic [7:0]    pk [NBYTES];
   logic [CW-1:0] pn;

   assign idle          = (state == IDLE) && (count == '0);
   assign strobe        = bus.send || bus.writeMeta;
   assign bus.xmit_idle = idle;
   assign bus.dataReady = (state != IDLE);
   assign bus.miso      = miso;
   assign bus.overrun   = overrun;

   // Pack enabled bytes densely, lowest byte first; meta wins over send.
   always_comb begin
      pn = '0;
      for (int i = 0; i < NBYTES; i++) pk[i] = '0;
      if (bus.writeMeta) begin
         pk[0] = bus.meta_data;
         pn    = CW'(1);
      end else if (bus.send) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (bus.send_en[i]) begin
               pk[pn[PW-1:0]] = bus.send_data[8*i +: 8];
               pn             = pn + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or posedge extReset) begin
      if (extReset) begin
         state   <= IDLE;
         for (int i = 0; i < NBYTES; i++) q[i] <= '0;
         count   <= '0;
         rdptr   <= '0;
         bitcnt  <= '0;
         shreg   <= '0;
         hold    <= '0;
         miso    <= 1'b0;
         overrun <= 1'b0;
         cs_q    <= 1'b1;
      end else begin
         cs_q <= bus.cs_n;
         if (strobe && (!idle || (bus.writeMeta && bus.send)))
            overrun <= 1'b1;
         unique case (state)
            IDLE: begin
               if (idle && strobe && pn != '0) begin
                  for (int i = 0; i < NBYTES; i++) q[i] <= pk[i];
                  count <= pn;
                  rdptr <= '0;
                  state <= LOAD;
               end
            end
            LOAD: begin
               shreg  <= q[rdptr];
               hold   <= q[rdptr];
               miso   <= q[rdptr][7];
               rdptr  <= rdptr + PW'(1);
               count  <= count - CW'(1);
               bitcnt <= '0;
               state  <= SHIFT;
            end
            SHIFT: begin
               // Host deselected mid-byte: rewind so the whole byte goes again.
               if (bus.cs_n && !cs_q) begin
                  shreg  <= hold;
                  bitcnt <= '0;
                  miso   <= hold[7];
               end else if (!bus.cs_n) begin
                  if (bus.sclk_rise) begin
                     bitcnt <= bitcnt + 3'd1;
                     if (bitcnt == 3'd7) state <= NEXT;
                  end else if (bus.sclk_fall && bitcnt != '0) begin
                     shreg <= {shreg[6:0], 1'b0};
                     miso  <= shreg[6];
                  end
               end
            end
            NEXT: state <= (count != '0) ? LOAD : IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_byte_sender.sv
// Randomised bench for spi_byte_sender against a byte-queue model of
// what the host should receive.
module tb_spi_byte_sender;
   logic clock = 1'b0;
   logic extReset;
   int   tests = 0;
   int   fails = 0;

   logic [7:0] expq[$];
   logic       ovr_m;

   always #5 clock = ~clock;

   spi_byte_sender_if bus ();

   spi_byte_sender dut (
      .clock    (clock),
      .extReset (extReset),
      .bus      (bus)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic sclk_cycle();
      bus.sclk_rise = 1'b1; step();
      bus.sclk_rise = 1'b0; step();
      bus.sclk_fall = 1'b1; step();
      bus.sclk_fall = 1'b0; step();
   endtask

   task automatic rd_byte(output logic [7:0] b, output logic i1,
                          output logic i2);
      b = '0;
      i1 = 1'b0;
      i2 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         b = {b[6:0], bus.miso};
         bus.sclk_rise = 1'b1; step();
         i1 = bus.xmit_idle;
         bus.sclk_rise = 1'b0; step();
         i2 = bus.xmit_idle;
         bus.sclk_fall = 1'b1; step();
         bus.sclk_fall = 1'b0; step();
      end
   endtask

   task automatic load(bit meta, logic [31:0] d, logic [3:0] en);
      if (meta) expq.push_back(d[7:0]);
      else
         for (int i = 0; i < 4; i++)
            if (en[i]) expq.push_back(8'((d >> (8 * i)) & 32'hFF));
      bus.writeMeta = meta;
      bus.send      = !meta;
      bus.meta_data = d[7:0];
      bus.send_data = d;
      bus.send_en   = en;
      step();
      bus.writeMeta = 1'b0;
      bus.send      = 1'b0;
      step();
   endtask

   task automatic drain(string tag);
      logic [7:0] b;
      logic       i1, i2;
      while (expq.size() > 0) begin
         check({tag, "_rdy"}, 32'(bus.dataReady), 32'd1);
         rd_byte(b, i1, i2);
         check({tag, "_byte"}, 32'(b), 32'(expq.pop_front()));
      end
      check({tag, "_idle1"}, 32'(i1), 32'd0);
      check({tag, "_idle2"}, 32'(i2), 32'd1);
      check({tag, "_rdy_end"}, 32'(bus.dataReady), 32'd0);
   endtask

   task automatic do_reset();
      extReset = 1'b1;
      step();
      check("rst_miso", 32'(bus.miso), 32'd0);
      check("rst_idle", 32'(bus.xmit_idle), 32'd1);
      check("rst_rdy", 32'(bus.dataReady), 32'd0);
      check("rst_ovr", 32'(bus.overrun), 32'd0);
      extReset = 1'b0;
      expq.delete();
      ovr_m = 1'b0;
      step();
   endtask

   initial begin
      logic [7:0]  b;
      logic        i1, i2;
      logic [31:0] d;
      logic [3:0]  en;
      bit          meta;

      bus.send = 0; bus.send_data = '0; bus.send_en = '0;
      bus.writeMeta = 0; bus.meta_data = '0;
      bus.cs_n = 0; bus.sclk_rise = 0; bus.sclk_fall = 0;
      extReset = 1'b0;
      ovr_m = 1'b0;
      step();
      do_reset();

      load(1'b1, 32'hA5, 4'h0);
      check("t1_lat", 32'(bus.miso), 32'd1);
      drain("t1");

      load(1'b0, 32'h44332211, 4'hF);
      drain("t2");

      load(1'b0, 32'hDDCCBBAA, 4'hA);
      drain("t3");

      expq.push_back(8'h5A);
      bus.writeMeta = 1; bus.meta_data = 8'h5A;
      bus.send = 1; bus.send_data = 32'h12345678; bus.send_en = 4'hF;
      step();
      bus.writeMeta = 0; bus.send = 0;
      step();
      ovr_m = 1'b1;
      check("t4_ovr", 32'(bus.overrun), 32'(ovr_m));
      drain("t4");

      load(1'b1, 32'h3C, 4'h0);
      for (int k = 0; k < 3; k++) sclk_cycle();
      check("t5_mid", 32'(bus.miso), 32'd1);
      bus.cs_n = 1'b1;
      step(); step();
      check("t5_rewind", 32'(bus.miso), 32'd0);
      sclk_cycle();
      sclk_cycle();
      check("t5_ign", 32'(bus.miso), 32'd0);
      bus.cs_n = 1'b0;
      step();
      drain("t5");

      do_reset();
      d = $urandom();
      load(1'b0, d, 4'hF);
      rd_byte(b, i1, i2);
      check("t6_b0", 32'(b), 32'(expq.pop_front()));
      for (int k = 0; k < 3; k++) sclk_cycle();
      do_reset();
      for (int k = 0; k < 8; k++) sclk_cycle();
      check("t6_miso", 32'(bus.miso), 32'd0);
      check("t6_rdy", 32'(bus.dataReady), 32'd0);
      check("t6_idle", 32'(bus.xmit_idle), 32'd1);

      for (int n = 0; n < 40; n++) begin
         meta = 1'($urandom_range(0, 3) == 0);
         d    = $urandom();
         en   = 4'($urandom());
         load(meta, d, en);
         if (expq.size() == 0) begin
            check("rnd_noop", 32'(bus.xmit_idle), 32'd1);
         end else begin
            if ($urandom_range(0, 2) == 0) begin
               bus.writeMeta = 1'($urandom());
               bus.send      = !bus.writeMeta;
               bus.send_en   = 4'hF;
               step();
               bus.writeMeta = 0; bus.send = 0;
               ovr_m = 1'b1;
            end
            drain("rnd");
         end
         check("rnd_ovr", 32'(bus.overrun), 32'(ovr_m));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
